sar_adc_seq: RTL and testbench

//  Parametrised successive-approximation ADC sequencer. Drives the external track/hold,
//  the serial-loaded trial DAC (ser/sclk/lclk) and samples the external comparator.

---
 rtl/sar_adc_seq_if.sv | 21 ++
 rtl/sar_adc_seq.sv | 172 +++++++++++++++++
 tb/tb_sar_adc_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_adc_seq_if.sv
// Result stream between the SAR sequencer and its consumer.
// Valid/ready handshake carrying the averaged conversion result.
interface sar_adc_seq_if #(
    parameter int WIDTH = 14
);
    logic [WIDTH-1:0] data_o;
    logic             data_valid_o;
    logic             data_ready_i;

    modport master (
        output data_o,
        output data_valid_o,
        input  data_ready_i
    );

    modport slave (
        input  data_o,
        input  data_valid_o,
        output data_ready_i
    );
endinterface

// File: rtl/sar_adc_seq.sv
// Successive-approximation ADC sequencer: track/hold, serial trial DAC,
// comparator sampling, 2^N averaging and a valid/ready result port.
module sar_adc_seq #(
    parameter int WIDTH     = 14,
    parameter int SR_WIDTH  = 16,
    parameter int CLK_DIV   = 2,
    parameter int SETTLE    = 8,
    parameter int SH_CYCLES = 16,
    parameter int AVG_LOG2  = 0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          continuous_i,
    output logic          sh_o,
    output logic          ser_o,
    output logic          sclk_o,
    output logic          lclk_o,
    input  logic          comp_i,
    output logic          busy_o,
    output logic          overrun_o,
    sar_adc_seq_if.master res
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
    localparam int AW = WIDTH + AVG_LOG2;
    localparam int NW = AVG_LOG2 + 1;
    localparam int CW = 16;

    typedef enum logic [2:0] {
        S_IDLE, S_TRACK, S_SHIFT, S_LATCH,
        S_SETTLE, S_DECIDE, S_ACCUM, S_OUTPUT
    } state_t;

    state_t              r_state;
    state_t              w_nxt;
    logic [CW-1:0]       r_cnt;
    logic [SW-1:0]       r_sidx;
    logic [KW-1:0]       r_k;
    logic [WIDTH-1:0]    r_sar;
    logic [AW-1:0]       r_acc;
    logic [NW-1:0]       r_conv;
    logic [1:0]          r_sync;
    logic [WIDTH-1:0]    r_data;
    logic                r_valid;
    logic                r_ovr;
    logic [WIDTH-1:0]    w_trial;
    logic [SR_WIDTH-1:0] w_word;
    logic                w_bit_end;
    logic                w_sh;
    logic                w_ser;
    logic                w_sclk;
    logic                w_lclk;

    assign w_trial   = r_sar | (WIDTH'(1) << r_k);
    assign w_word    = SR_WIDTH'(w_trial);
    assign w_bit_end = (r_cnt == CW'(2 * CLK_DIV - 1));

    // State register; reset returns to IDLE immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) r_state <= S_IDLE;
        else         r_state <= w_nxt;
    end

    // Next state and pin levels decoded from state and phase counters.
    always_comb begin
        w_nxt  = r_state;
        w_sh   = 1'b0;
        w_ser  = 1'b0;
        w_sclk = 1'b0;
        w_lclk = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_sh = 1'b1;
                if (start_i || continuous_i) w_nxt = S_TRACK;
            end
            S_TRACK: begin
                w_sh = 1'b1;
                if (r_cnt == CW'(SH_CYCLES - 1)) w_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_ser  = w_word[SW'(SR_WIDTH - 1) - r_sidx];
                w_sclk = (r_cnt >= CW'(CLK_DIV));
                if (w_bit_end && r_sidx == SW'(SR_WIDTH - 1))
                    w_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_lclk = 1'b1;
                if (r_cnt == CW'(CLK_DIV - 1)) w_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == CW'(SETTLE - 1)) w_nxt = S_DECIDE;
            end
            S_DECIDE: begin
                w_nxt = (r_k == '0) ? S_ACCUM : S_SHIFT;
            end
            S_ACCUM: begin
                if (r_conv == NW'((1 << AVG_LOG2) - 1)) w_nxt = S_OUTPUT;
                else                                     w_nxt = S_TRACK;
            end
            S_OUTPUT: begin
                w_sh  = 1'b1;
                w_nxt = continuous_i ? S_TRACK : S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // Phase counters, comparator synchroniser and SAR/averaging datapath.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt  <= '0;
            r_sidx <= '0;
            r_k    <= '0;
            r_sar  <= '0;
            r_acc  <= '0;
            r_conv <= '0;
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], comp_i};
            if (w_nxt != r_state || r_state == S_IDLE)
                r_cnt <= '0;
            else if (r_state == S_SHIFT && w_bit_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + CW'(1);
            if (r_state != S_SHIFT) r_sidx <= '0;
            else if (w_bit_end)     r_sidx <= r_sidx + SW'(1);
            if (r_state != S_TRACK && w_nxt == S_TRACK) begin
                r_sar <= '0;
                r_k   <= KW'(WIDTH - 1);
            end
            if (r_state == S_DECIDE) begin
                if (r_sync[1]) r_sar <= w_trial;
                if (r_k != '0) r_k <= r_k - KW'(1);
            end
            if (r_state == S_ACCUM) begin
                r_acc  <= r_acc + AW'(r_sar);
                r_conv <= r_conv + NW'(1);
            end
            if (r_state == S_OUTPUT) begin
                r_acc  <= '0;
                r_conv <= '0;
            end
        end
    end

    // Result register with valid/ready handshake and overrun flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else if (r_state == S_OUTPUT) begin
            r_data  <= WIDTH'(r_acc >> AVG_LOG2);
            r_valid <= 1'b1;
            r_ovr   <= r_valid & ~res.data_ready_i;
        end else begin
            r_ovr <= 1'b0;
            if (r_valid && res.data_ready_i) r_valid <= 1'b0;
        end
    end

    assign sh_o             = w_sh;
    assign ser_o            = w_ser;
    assign sclk_o           = w_sclk;
    assign lclk_o           = w_lclk;
    assign busy_o           = (r_state != S_IDLE);
    assign overrun_o        = r_ovr;
    assign res.data_o       = r_data;
    assign res.data_valid_o = r_valid;
endmodule

// File: tb/tb_sar_adc_seq.sv
// Bench for sar_adc_seq: two configurations driven by an ideal DAC and
// comparator model, results checked against plain SAR/averaging arithmetic.
module tb_sar_adc_seq;
    logic clk;
    logic rst;
    logic startA, contA, shA, serA, sclkA, lclkA, compA, busyA, ovrA;
    logic startB, contB, shB, serB, sclkB, lclkB, compB, busyB, ovrB;
    int   n_chk = 0;
    int   n_fail = 0;

    sar_adc_seq_if #(.WIDTH(4)) ifa ();
    sar_adc_seq_if #(.WIDTH(6)) ifb ();

    sar_adc_seq #(
        .WIDTH(4), .SR_WIDTH(6), .CLK_DIV(1),
        .SETTLE(3), .SH_CYCLES(2), .AVG_LOG2(0)
    ) u_a (
        .clk_i(clk), .reset_i(rst), .start_i(startA),
        .continuous_i(contA), .sh_o(shA), .ser_o(serA),
        .sclk_o(sclkA), .lclk_o(lclkA), .comp_i(compA),
        .busy_o(busyA), .overrun_o(ovrA), .res(ifa)
    );

    sar_adc_seq #(
        .WIDTH(6), .SR_WIDTH(8), .CLK_DIV(2),
        .SETTLE(4), .SH_CYCLES(3), .AVG_LOG2(2)
    ) u_b (
        .clk_i(clk), .reset_i(rst), .start_i(startB),
        .continuous_i(contB), .sh_o(shB), .ser_o(serB),
        .sclk_o(sclkB), .lclk_o(lclkB), .comp_i(compB),
        .busy_o(busyB), .overrun_o(ovrB), .res(ifb)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // External DAC shift/latch registers and sample-and-hold models
    logic [5:0] srA, dacA;
    logic [7:0] srB, dacB;
    int qA[$], qB[$], logA[$];
    int vhA = 0, vhB = 0;

    always @(posedge sclkA) srA <= {srA[4:0], serA};
    always @(posedge lclkA) begin
        dacA <= srA;
        logA.push_back(int'(srA));
    end
    always @(posedge sclkB) srB <= {srB[6:0], serB};
    always @(posedge lclkB) dacB <= srB;
    always @(negedge shA) if (qA.size() > 0) vhA = qA.pop_front();
    always @(negedge shB) if (qB.size() > 0) vhB = qB.pop_front();
    assign compA = (vhA >= int'(dacA));
    assign compB = (vhB >= int'(dacB));

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Code loaded for bit k: bits of the answer above k, then bit k set.
    function automatic int exp_trial(input int vin, input int k);
        return ((vin >> (k + 1)) << (k + 1)) | (1 << k);
    endfunction

    task automatic wait_valid(input bit b, output int lat);
        lat = 1;
        while (!(b ? ifb.data_valid_o : ifa.data_valid_o) && lat < 3000) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (lat >= 3000) check("valid_timeout", 0, 1);
    endtask

    task automatic consume(input bit b);
        @(posedge clk);
        #1;
        if (b) ifb.data_ready_i = 1; else ifa.data_ready_i = 1;
        @(posedge clk);
        #1;
        ifa.data_ready_i = 0;
        ifb.data_ready_i = 0;
        check("consumed", b ? ifb.data_valid_o : ifa.data_valid_o, 0);
    endtask

    task automatic conv_a(input int vin, input string tag, input bit eat);
        int lat;
        qA.push_back(vin);
        logA.delete();
        @(posedge clk); #1 startA = 1;
        @(posedge clk); #1 startA = 0;
        wait_valid(0, lat);
        check({tag, "_lat"}, lat, 73);
        check({tag, "_data"}, ifa.data_o, vin);
        check({tag, "_nload"}, logA.size(), 4);
        if (logA.size() == 4)
            for (int k = 3; k >= 0; k--)
                check({tag, "_dac"}, logA[3 - k], exp_trial(vin, k));
        if (eat) consume(0);
    endtask

    task automatic run_b(input int v0, v1, v2, v3, input string tag);
        int lat;
        qB.push_back(v0); qB.push_back(v1);
        qB.push_back(v2); qB.push_back(v3);
        @(posedge clk); #1 startB = 1;
        @(posedge clk); #1 startB = 0;
        wait_valid(1, lat);
        check({tag, "_lat"}, lat, 954);
        check({tag, "_data"}, ifb.data_o, (v0 + v1 + v2 + v3) / 4);
        check({tag, "_ovr"}, ovrB, 0);
        consume(1);
    endtask

    initial begin
        int lat, cyc, v[4];
        bit saw_ovr, moved;
        rst = 1;
        startA = 0; contA = 0; startB = 0; contB = 0;
        ifa.data_ready_i = 0;
        ifb.data_ready_i = 0;
        #2;
        check("rst_sh", shA, 1);
        check("rst_ser", serA, 0);
        check("rst_sclk", sclkA, 0);
        check("rst_lclk", lclkA, 0);
        check("rst_data", ifa.data_o, 0);
        check("rst_valid", ifa.data_valid_o, 0);
        check("rst_busy", busyA, 0);
        check("rst_ovr", ovrA, 0);
        check("rst_b_valid", ifb.data_valid_o, 0);
        repeat (3) @(posedge clk);
        #1 rst = 0;

        conv_a(9, "a_vin9", 1);
        conv_a(15, "a_max", 1);
        conv_a(0, "a_min", 1);
        for (int i = 0; i < 6; i++) conv_a($urandom_range(0, 15), "a_rand", 1);

        run_b(40, 41, 42, 43, "b_seq");
        run_b(63, 63, 63, 63, "b_max");
        run_b(0, 0, 0, 0, "b_min");
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) v[j] = $urandom_range(0, 63);
            run_b(v[0], v[1], v[2], v[3], "b_rand");
        end

        // Continuous mode with an unread result: overrun then drop out.
        qA.push_back(5); qA.push_back(11);
        qA.push_back(3); qA.push_back(3);
        contA = 1;
        wait_valid(0, lat);
        check("ovr_first", ifa.data_o, 5);
        cyc = 0;
        while (!ovrA && cyc < 300) begin
            @(posedge clk); cyc++; #1;
        end
        check("ovr_pulse", ovrA, 1);
        check("ovr_data", ifa.data_o, 11);
        check("ovr_valid", ifa.data_valid_o, 1);
        @(posedge clk); #1;
        check("ovr_width", ovrA, 0);
        contA = 0;
        ifa.data_ready_i = 1;
        cyc = 0;
        while (busyA && cyc < 300) begin
            @(posedge clk); cyc++; #1;
        end
        check("cont_stop", busyA, 0);
        check("cont_last", ifa.data_o, 3);
        @(posedge clk); #1;
        ifa.data_ready_i = 0;
        check("cont_drain", ifa.data_valid_o, 0);
        qA.delete();

        // Reset during the DAC shift phase.
        conv_a(5, "pre_rst", 0);
        qA.push_back(3);
        @(posedge clk); #1 startA = 1;
        @(posedge clk); #1 startA = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("in_shift", shA, 0);
        rst = 1;
        #1;
        check("mrst_sh", shA, 1);
        check("mrst_ser", serA, 0);
        check("mrst_sclk", sclkA, 0);
        check("mrst_lclk", lclkA, 0);
        check("mrst_busy", busyA, 0);
        check("mrst_valid", ifa.data_valid_o, 0);
        check("mrst_data", ifa.data_o, 0);
        @(posedge clk); #1 rst = 0;
        qA.delete();
        conv_a(6, "post_rst", 1);

        // Start while busy; ready coincident with the result update.
        conv_a(2, "t6_pre", 0);
        qA.push_back(12);
        logA.delete();
        saw_ovr = 0;
        moved = 0;
        @(posedge clk); #1 startA = 1;
        @(posedge clk); #1 startA = 0;
        for (lat = 2; lat <= 73; lat++) begin
            @(posedge clk); #1;
            if (ovrA) saw_ovr = 1;
            if (lat < 73 && ifa.data_o != 2) moved = 1;
            if (lat == 20) startA = 1;
            if (lat == 21) startA = 0;
            if (lat == 72) ifa.data_ready_i = 1;
        end
        ifa.data_ready_i = 0;
        check("t6_hold", moved, 0);
        check("t6_valid", ifa.data_valid_o, 1);
        check("t6_data", ifa.data_o, 12);
        check("t6_nload", logA.size(), 4);
        repeat (10) begin
            @(posedge clk); #1;
            if (ovrA || busyA) saw_ovr = 1;
        end
        check("t6_no_ovr_restart", saw_ovr, 0);
        consume(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
